rv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation RISC-V core.
- Replaces the combinational PC-register plus instruction-memory path with a handshaked fetch engine.
- Issues requests to a variable-latency instruction memory and buffers returned words with their PC in a prefetch FIFO.
- Presents instructions to decode over valid/ready and supports branch/jump redirect with flush of buffered and in-flight fetches.

---
 rtl/rv_pkg.sv | 17 +
 rtl/rv_fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/rv_fetch_unit.sv | 80 ++++++++
 tb/tb_rv_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared types and defaults for the RISC-V instruction-fetch front end.
package rv_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INSN_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         insn;
    } fetch_entry_t;
endpackage

// File: rtl/rv_fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch unit; master = fetch unit.
interface rv_fetch_unit_if import rv_pkg::*; #(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4
);
    logic                         imem_req;
    logic [XLEN-1:0]              imem_addr;
    logic                         imem_ack;
    logic [31:0]                  imem_rdata;
    logic                         inst_valid;
    logic [31:0]                  inst_data;
    logic [XLEN-1:0]              inst_pc;
    logic [XLEN-1:0]              inst_pc_plus4;
    logic                         inst_ready;
    logic                         redirect;
    logic [XLEN-1:0]              redirect_pc;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4, fifo_count,
        input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4, fifo_count,
        output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head word is visible combinationally and reads 0 when empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Requests are only issued when a slot is guaranteed, so this must never fire.
    always @(posedge clk) begin
        if (rst_n && !flush) assert (!(push && full)) else $error("fetch_fifo: push into full FIFO");
    end
endmodule

// File: rtl/rv_fetch_unit.sv
// Handshaked instruction-fetch engine: one outstanding memory request, prefetch FIFO, redirect with flush.
module rv_fetch_unit import rv_pkg::*; #(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    rv_fetch_unit_if.master bus
);
    // state | meaning
    // IDLE  | no request outstanding, waiting for FIFO room
    // REQ   | request for fetch_pc on the bus
    // DROP  | abandoned request at drop_addr awaiting its ack, data discarded
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t     state, state_next;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  drop_addr;
    logic [XLEN-1:0]  redirect_aligned;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             ack;
    logic             push;
    logic             pop;
    logic             empty;
    logic [XLEN+31:0] head;

    assign redirect_aligned = bus.redirect_pc & ~XLEN'(3);
    assign ack  = bus.imem_ack && (state != IDLE);
    assign push = ack && (state == REQ) && !bus.redirect;
    assign pop  = !empty && bus.inst_ready && !bus.redirect;
    assign count_next = bus.redirect ? '0 : count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            state <= state_next;
            if (state == REQ && bus.redirect && !ack) drop_addr <= fetch_pc;
            if (bus.redirect)  fetch_pc <= redirect_aligned;
            else if (push)     fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    always_comb begin
        state_next    = state;
        bus.imem_req  = (state != IDLE);
        bus.imem_addr = (state == DROP) ? drop_addr : fetch_pc;
        case (state)
            IDLE: if (count_next < CW'(DEPTH)) state_next = REQ;
            REQ: begin
                if (bus.redirect)                          state_next = ack ? REQ : DROP;
                else if (ack && count_next >= CW'(DEPTH))  state_next = IDLE;
            end
            DROP: if (ack) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    fetch_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata ({fetch_pc, bus.imem_rdata}),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    assign bus.inst_valid    = !empty;
    assign bus.inst_pc       = head[XLEN+31:32];
    assign bus.inst_data     = head[31:0];
    assign bus.inst_pc_plus4 = empty ? '0 : head[XLEN+31:32] + XLEN'(4);
    assign bus.fifo_count    = count;
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: queue-based reference model checked every cycle plus literal pins.
module tb_rv_fetch_unit;
    import rv_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] SALT  = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rv_fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
    rv_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model
    fetch_entry_t q[$];
    logic [31:0]  m_pc;
    logic [31:0]  m_drop_addr;
    bit           m_drop;
    bit           m_req;

    // memory / redirect environment
    int          lat = 0;
    int          wait_cnt = 0;
    bit          redir_arm = 0;
    int          redir_mode = 0;
    bit          redir_any = 1;
    logic [31:0] redir_match = '0;
    logic [31:0] redir_target = '0;
    bit          watch_en = 0;
    logic [31:0] watch_pc = '0;
    int          seen_watch = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc        = RPC;
        m_drop_addr = RPC;
        m_drop      = 0;
        m_req       = 0;
    endtask

    task automatic compare();
        chk("imem_req", 64'(bus.imem_req), 64'(m_req));
        chk("imem_addr", 64'(bus.imem_addr), 64'(m_drop ? m_drop_addr : m_pc));
        chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        chk("inst_valid", 64'(bus.inst_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("inst_pc", 64'(bus.inst_pc), 64'(q[0].pc));
            chk("inst_data", 64'(bus.inst_data), 64'(q[0].insn));
            chk("inst_pc_plus4", 64'(bus.inst_pc_plus4), 64'(q[0].pc + 32'd4));
        end else begin
            chk("empty_pc", 64'(bus.inst_pc), 64'd0);
            chk("empty_data", 64'(bus.inst_data), 64'd0);
            chk("empty_plus4", 64'(bus.inst_pc_plus4), 64'd0);
        end
        if (watch_en && bus.inst_valid && bus.inst_pc == watch_pc) seen_watch++;
    endtask

    // Advance the model by the clock edge that follows, using the inputs now on the bus.
    task automatic model_step();
        fetch_entry_t e;
        bit           acked;
        acked = m_req && bus.imem_ack;
        if (bus.redirect) begin
            if (m_req && !bus.imem_ack) begin
                if (!m_drop) m_drop_addr = m_pc;
                m_drop = 1;
            end else begin
                m_drop = 0;
            end
            m_pc = bus.redirect_pc & ~32'h3;
            q.delete();
        end else begin
            if (q.size() != 0 && bus.inst_ready) void'(q.pop_front());
            if (acked) begin
                if (m_drop) begin
                    m_drop = 0;
                end else begin
                    e.pc   = m_pc;
                    e.insn = bus.imem_rdata;
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_req = bus.redirect || m_drop || (q.size() < DEPTH);
    endtask

    // Compare, then play the memory and the redirect source for the coming edge.
    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_reset();
                bus.imem_ack = 1'b0;
                bus.redirect = 1'b0;
                wait_cnt     = 0;
            end
            compare();
            if (rst) begin
                if (bus.imem_req) begin
                    if (wait_cnt >= lat) begin
                        bus.imem_ack = 1'b1;
                        wait_cnt     = 0;
                    end else begin
                        bus.imem_ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    bus.imem_ack = 1'b0;
                    wait_cnt     = 0;
                end
                bus.imem_rdata = bus.imem_addr ^ SALT;
                bus.redirect   = 1'b0;
                if (redir_arm && (redir_any || bus.imem_addr == redir_match) &&
                    (redir_mode == 0 ||
                     (redir_mode == 1 && bus.imem_ack) ||
                     (redir_mode == 2 && bus.imem_req && !bus.imem_ack))) begin
                    bus.redirect    = 1'b1;
                    bus.redirect_pc = redir_target;
                    redir_arm       = 0;
                end
                model_step();
            end
        end
    end

    task automatic do_reset(input bit ready_v, input int lat_v);
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.inst_ready = ready_v;
        lat            = lat_v;
        redir_arm      = 0;
        watch_en       = 0;
        seen_watch     = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic arm(input int mode, input bit any, input logic [31:0] match, input logic [31:0] target);
        redir_mode   = mode;
        redir_any    = any;
        redir_match  = match;
        redir_target = target;
        redir_arm    = 1;
    endtask

    task automatic wait_full(input string name);
        int n = 0;
        while (!(bus.fifo_count == 3'(DEPTH) && !bus.imem_req) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_full_timeout"}, 64'(n < 40), 64'd1);
    endtask

    task automatic wait_fire(input string name);
        int n = 0;
        while (redir_arm && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_redirect_timeout"}, 64'(n < 40), 64'd1);
        redir_arm = 0;
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a);
        int n = 0;
        while (!(bus.imem_req && bus.imem_addr == a) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_addr_timeout"}, 64'(n < 20), 64'd1);
    endtask

    task automatic wait_count(input string name, input int c);
        int n = 0;
        while (!(bus.fifo_count == 3'(c)) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_count_timeout"}, 64'(n < 20), 64'd1);
    endtask

    initial begin
        bus.inst_ready = 1'b1;
        #1;
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'(RPC));
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_valid", 64'(bus.inst_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // zero-wait streaming
        @(posedge clk); #1;
        chk("t1_first_req", 64'(bus.imem_req), 64'd1);
        chk("t1_first_addr", 64'(bus.imem_addr), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t1_valid", 64'(bus.inst_valid), 64'd1);
            chk("t1_pc", 64'(bus.inst_pc), 64'(i * 4));
            chk("t1_data", 64'(bus.inst_data), 64'(32'(i * 4) ^ SALT));
            chk("t1_plus4", 64'(bus.inst_pc_plus4), 64'(i * 4 + 4));
        end

        // back-pressure fills FIFO, then resumes at 0x10
        do_reset(0, 0);
        wait_full("t2");
        repeat (3) @(posedge clk);
        #1;
        chk("t2_count", 64'(bus.fifo_count), 64'd4);
        chk("t2_req", 64'(bus.imem_req), 64'd0);
        chk("t2_head", 64'(bus.inst_pc), 64'h0);
        bus.inst_ready = 1'b1;
        @(posedge clk); #1;
        chk("t2_resume_req", 64'(bus.imem_req), 64'd1);
        chk("t2_resume_addr", 64'(bus.imem_addr), 64'h10);
        chk("t2_head_after_pop", 64'(bus.inst_pc), 64'h4);
        repeat (10) @(posedge clk);

        // redirect with full FIFO and nothing in flight
        do_reset(0, 0);
        wait_full("t3");
        arm(0, 1, '0, 32'h100);
        wait_fire("t3");
        chk("t3_count", 64'(bus.fifo_count), 64'd0);
        chk("t3_valid", 64'(bus.inst_valid), 64'd0);
        chk("t3_addr", 64'(bus.imem_addr), 64'h100);
        bus.inst_ready = 1'b1;
        repeat (8) @(posedge clk);

        // redirect while 0x8 outstanding on a 3-cycle memory
        do_reset(1, 2);
        watch_pc = 32'h8;
        watch_en = 1;
        arm(2, 0, 32'h8, 32'h200);
        wait_fire("t4");
        chk("t4_hold_req", 64'(bus.imem_req), 64'd1);
        chk("t4_hold_addr", 64'(bus.imem_addr), 64'h8);
        @(posedge clk); #1;
        chk("t4_hold_addr2", 64'(bus.imem_addr), 64'h8);
        wait_addr("t4", 32'h200);
        repeat (12) @(posedge clk);
        chk("t4_dropped_word_seen", 64'(seen_watch), 64'd0);
        watch_en = 0;

        // redirect coincident with ack, unaligned target
        do_reset(1, 0);
        watch_pc   = 32'hC;
        seen_watch = 0;
        watch_en   = 1;
        arm(1, 0, 32'hC, 32'h103);
        wait_fire("t5");
        chk("t5_valid", 64'(bus.inst_valid), 64'd0);
        chk("t5_req", 64'(bus.imem_req), 64'd1);
        chk("t5_addr", 64'(bus.imem_addr), 64'h100);
        repeat (6) @(posedge clk);
        chk("t5_dropped_word_seen", 64'(seen_watch), 64'd0);
        watch_en = 0;

        // asynchronous reset mid-request
        do_reset(0, 0);
        wait_count("t6", 2);
        chk("t6_pre_req", 64'(bus.imem_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_req", 64'(bus.imem_req), 64'd0);
        chk("t6_async_valid", 64'(bus.inst_valid), 64'd0);
        chk("t6_async_count", 64'(bus.fifo_count), 64'd0);
        chk("t6_async_addr", 64'(bus.imem_addr), 64'(RPC));
        @(posedge clk); #1;
        rst            = 1'b1;
        bus.inst_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_restart_req", 64'(bus.imem_req), 64'd1);
        chk("t6_restart_addr", 64'(bus.imem_addr), 64'(RPC));
        repeat (6) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
